// File: rtl/spi_master_seq.sv
// spi_master_seq: SPI mode-0 master transaction sequencer.
// Frames multi-word transfers under chip-select, shifting MSB-first in both
// directions. The serial clock comes from an external generator together with
// one-cycle edge strobes; this block only gates that clock onto the pin.
module spi_master_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_in,
  input  logic             sclk_pos_edge,
  input  logic             sclk_neg_edge,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  input  logic             tx_last,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             spi_sclk,
  output logic             spi_cs_n,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BIT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] BIT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  tx_sh_r;
  logic [WIDTH-1:0]  rx_sh_r;
  logic [CW-1:0]     bitcnt_r;
  logic              cur_last_r;
  logic [WIDTH-1:0]  nxt_data_r;
  logic              nxt_last_r;
  logic              nxt_vld_r;
  logic              gate_r;
  logic              cs_n_r;
  logic              mosi_r;
  logic [WIDTH-1:0]  rx_data_r;
  logic              rx_valid_r;

  logic              pos_s;
  logic              neg_s;
  logic              acc_s;
  logic              tx_ready_s;
  logic              busy_s;

  // A simultaneous pair of strobes is illegal; the rising one wins.
  assign pos_s = sclk_pos_edge;
  assign neg_s = sclk_neg_edge & ~sclk_pos_edge;
  assign acc_s = tx_valid & tx_ready_s;

  // Ready decode: open in IDLE, otherwise only while no word is queued and the
  // word in flight does not close the transaction.
  always_comb begin
    tx_ready_s = 1'b0;
    busy_s     = 1'b1;
    case (state_r)
      ST_IDLE: begin
        tx_ready_s = 1'b1;
        busy_s     = 1'b0;
      end
      ST_LOAD, ST_SHIFT, ST_WAIT: begin
        if (!nxt_vld_r && !cur_last_r) begin
          tx_ready_s = 1'b1;
        end else begin
          tx_ready_s = 1'b0;
        end
      end
      default: tx_ready_s = 1'b0;
    endcase
  end

  // Transaction FSM with shift registers, holding register and pin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      tx_sh_r    <= {WIDTH{1'b0}};
      rx_sh_r    <= {WIDTH{1'b0}};
      bitcnt_r   <= {CW{1'b0}};
      cur_last_r <= 1'b0;
      nxt_data_r <= {WIDTH{1'b0}};
      nxt_last_r <= 1'b0;
      nxt_vld_r  <= 1'b0;
      gate_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      mosi_r     <= 1'b0;
      rx_data_r  <= {WIDTH{1'b0}};
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      // Words arriving mid-transaction wait in the holding register.
      if (acc_s && (state_r != ST_IDLE)) begin
        nxt_data_r <= tx_data;
        nxt_last_r <= tx_last;
        nxt_vld_r  <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          gate_r <= 1'b0;
          if (acc_s) begin
            tx_sh_r    <= tx_data;
            cur_last_r <= tx_last;
            cs_n_r     <= 1'b0;
            mosi_r     <= tx_data[WIDTH-1];
            state_r    <= ST_LOAD;
          end else begin
            cs_n_r <= 1'b1;
            mosi_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          // Opening the gate just after a falling strobe gives a half period
          // of MOSI/CS setup before the first rising edge.
          if (neg_s) begin
            gate_r   <= 1'b1;
            bitcnt_r <= {CW{1'b0}};
            state_r  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (pos_s) begin
            rx_sh_r  <= {rx_sh_r[WIDTH-2:0], spi_miso};
            bitcnt_r <= bitcnt_r + BIT_ONE;
          end else if (neg_s) begin
            if (bitcnt_r < BIT_FULL) begin
              // Rotate rather than shift; the wrapped bit is never driven out.
              tx_sh_r <= {tx_sh_r[WIDTH-2:0], tx_sh_r[WIDTH-1]};
              mosi_r  <= tx_sh_r[WIDTH-2];
            end else begin
              rx_data_r  <= rx_sh_r;
              rx_valid_r <= 1'b1;
              if (cur_last_r) begin
                gate_r  <= 1'b0;
                state_r <= ST_HOLD;
              end else if (nxt_vld_r) begin
                tx_sh_r    <= nxt_data_r;
                cur_last_r <= nxt_last_r;
                nxt_vld_r  <= 1'b0;
                mosi_r     <= nxt_data_r[WIDTH-1];
                bitcnt_r   <= {CW{1'b0}};
              end else begin
                gate_r  <= 1'b0;
                state_r <= ST_WAIT;
              end
            end
          end
        end
        ST_WAIT: begin
          gate_r <= 1'b0;
          if (nxt_vld_r) begin
            tx_sh_r    <= nxt_data_r;
            cur_last_r <= nxt_last_r;
            nxt_vld_r  <= 1'b0;
            mosi_r     <= nxt_data_r[WIDTH-1];
            state_r    <= ST_LOAD;
          end else if (acc_s) begin
            // Word accepted this very cycle bypasses the holding register.
            tx_sh_r    <= tx_data;
            cur_last_r <= tx_last;
            nxt_vld_r  <= 1'b0;
            mosi_r     <= tx_data[WIDTH-1];
            state_r    <= ST_LOAD;
          end
        end
        ST_HOLD: begin
          if (neg_s) begin
            cs_n_r  <= 1'b1;
            state_r <= ST_GAP;
          end
        end
        ST_GAP: begin
          // One full serial period of CS high before the next transaction.
          if (neg_s) begin
            mosi_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gate_r  <= 1'b0;
          cs_n_r  <= 1'b1;
          mosi_r  <= 1'b0;
        end
      endcase
    end
  end

  assign spi_sclk = sclk_in & gate_r;
  assign spi_cs_n = cs_n_r;
  assign spi_mosi = mosi_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign tx_ready = tx_ready_s;
  assign busy     = busy_s;

endmodule
